uart_regs: RTL and testbench

UART_REGS -- requirements
Module: uart_regs

---
 rtl/uart_pkg.sv | 32 +++
 rtl/uart_sync_fifo.sv | 58 +++++
 rtl/uart_regs.sv | 188 ++++++++++++++++++
 tb/tb_uart_regs.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - register map, field positions and error type for the UART register block
package uart_pkg;

    localparam logic [31:0] REG_CTRL   = 32'd0;
    localparam logic [31:0] REG_BAUD   = 32'd1;
    localparam logic [31:0] REG_STATUS = 32'd2;
    localparam logic [31:0] REG_TXDATA = 32'd3;
    localparam logic [31:0] REG_RXDATA = 32'd4;

    localparam int CTRL_W      = 5;
    localparam int CTRL_TX_EN  = 0;
    localparam int CTRL_RX_EN  = 1;
    localparam int CTRL_RX_IE  = 2;
    localparam int CTRL_TX_IE  = 3;
    localparam int CTRL_ERR_IE = 4;

    localparam int ST_TX_FULL   = 0;
    localparam int ST_TX_EMPTY  = 1;
    localparam int ST_RX_FULL   = 2;
    localparam int ST_RX_EMPTY  = 3;
    localparam int ST_OVERRUN   = 4;
    localparam int ST_FRAME_ERR = 5;
    localparam int ST_TX_LEVEL  = 8;
    localparam int ST_RX_LEVEL  = 16;

    typedef enum logic [1:0] {
        ERR_NONE   = 2'd0,
        ERR_DECODE = 2'd1,
        ERR_FIFO   = 2'd2
    } uart_err_e;

endpackage

// File: rtl/uart_sync_fifo.sv
// rtl/uart_sync_fifo.sv - single-clock FIFO with extra-bit pointers and show-ahead head
module uart_sync_fifo
    import uart_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push,
    input  logic [WIDTH-1:0]       push_data,
    input  logic                   pop,
    output logic [WIDTH-1:0]       pop_data,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] level
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_LEVEL = {1'b1, {AW{1'b0}}};
    localparam logic [AW:0] PTR_ONE    = {{AW{1'b0}}, 1'b1};

    logic [AW:0]      wptr_q, wptr_d;
    logic [AW:0]      rptr_q, rptr_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             do_push;
    logic             do_pop;

    // A push into a full FIFO is accepted when the head leaves in the same cycle.
    always_comb begin
        level   = wptr_q - rptr_q;
        empty   = (wptr_q == rptr_q);
        full    = (level == FULL_LEVEL);
        do_pop  = pop & ~empty;
        do_push = push & (~full | do_pop);
        wptr_d  = do_push ? wptr_q + PTR_ONE : wptr_q;
        rptr_d  = do_pop  ? rptr_q + PTR_ONE : rptr_q;
    end

    assign pop_data = mem_q[rptr_q[AW-1:0]];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wptr_q[AW-1:0]] <= push_data;
        end
    end

endmodule

// File: rtl/uart_regs.sv
// rtl/uart_regs.sv - UART control/status register block with TX and RX byte FIFOs
module uart_regs
    import uart_pkg::*;
#(
    parameter int              DATA_WIDTH     = 32,
    parameter int              REG_ADDR_WIDTH = 4,
    parameter int              FIFO_DEPTH     = 16,
    parameter logic [15:0]     BAUD_RESET     = 16'd434
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [REG_ADDR_WIDTH-1:0] reg_addr,
    input  logic [DATA_WIDTH-1:0]     reg_wdata,
    input  logic [DATA_WIDTH/8-1:0]   reg_wstrb,
    input  logic                      reg_wen,
    input  logic                      reg_ren,
    output logic [DATA_WIDTH-1:0]     reg_rdata,
    output logic                      reg_error,
    output logic [7:0]                tx_data,
    output logic                      tx_valid,
    input  logic                      tx_ready,
    input  logic [7:0]                rx_data,
    input  logic                      rx_valid,
    input  logic                      rx_frame_err,
    output logic                      tx_en,
    output logic                      rx_en,
    output logic [15:0]               baud_div,
    output logic                      irq
);

    localparam int LW = $clog2(FIFO_DEPTH) + 1;

    logic [CTRL_W-1:0]     ctrl_q, ctrl_d;
    logic [15:0]           baud_q, baud_d;
    logic                  overrun_q, overrun_d;
    logic                  frame_err_q, frame_err_d;
    logic                  irq_q, irq_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    uart_err_e             rd_err_q, rd_err_d;
    uart_err_e             wr_err;

    logic                  tx_push, tx_pop, tx_full, tx_empty;
    logic [LW-1:0]         tx_level;
    logic                  rx_push, rx_pop, rx_full, rx_empty;
    logic [LW-1:0]         rx_level;
    logic [7:0]            rx_head;

    logic [31:0]           addr_ext;
    logic [DATA_WIDTH-1:0] status_word;
    logic                  ovr_clr, fe_clr;
    logic                  unused_bits;

    assign unused_bits = ^{reg_wdata, reg_wstrb};

    uart_sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (tx_push),
        .push_data (reg_wdata[7:0]),
        .pop       (tx_pop),
        .pop_data  (tx_data),
        .full      (tx_full),
        .empty     (tx_empty),
        .level     (tx_level)
    );

    uart_sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (rx_push),
        .push_data (rx_data),
        .pop       (rx_pop),
        .pop_data  (rx_head),
        .full      (rx_full),
        .empty     (rx_empty),
        .level     (rx_level)
    );

    assign tx_en     = ctrl_q[CTRL_TX_EN];
    assign rx_en     = ctrl_q[CTRL_RX_EN];
    assign baud_div  = baud_q;
    assign irq       = irq_q;
    assign reg_rdata = rdata_q;
    assign tx_valid  = tx_en & ~tx_empty;
    assign tx_pop    = tx_valid & tx_ready;
    assign rx_push   = rx_valid & rx_en;
    assign reg_error = reg_wen ? (wr_err != ERR_NONE) : (rd_err_q != ERR_NONE);

    always_comb begin
        addr_ext                         = 32'(reg_addr);
        status_word                      = '0;
        status_word[ST_TX_FULL]          = tx_full;
        status_word[ST_TX_EMPTY]         = tx_empty;
        status_word[ST_RX_FULL]          = rx_full;
        status_word[ST_RX_EMPTY]         = rx_empty;
        status_word[ST_OVERRUN]          = overrun_q;
        status_word[ST_FRAME_ERR]        = frame_err_q;
        status_word[ST_TX_LEVEL +: LW]   = tx_level;
        status_word[ST_RX_LEVEL +: LW]   = rx_level;
    end

    always_comb begin
        ctrl_d   = ctrl_q;
        baud_d   = baud_q;
        wr_err   = ERR_NONE;
        tx_push  = 1'b0;
        ovr_clr  = 1'b0;
        fe_clr   = 1'b0;
        rdata_d  = rdata_q;
        rd_err_d = rd_err_q;
        rx_pop   = 1'b0;

        if (reg_wen) begin
            case (addr_ext)
                REG_CTRL: begin
                    if (reg_wstrb[0]) ctrl_d = reg_wdata[CTRL_W-1:0];
                end
                REG_BAUD: begin
                    if (reg_wstrb[0]) baud_d[7:0]  = reg_wdata[7:0];
                    if (reg_wstrb[1]) baud_d[15:8] = reg_wdata[15:8];
                end
                REG_STATUS: begin
                    if (reg_wstrb[0]) begin
                        ovr_clr = reg_wdata[ST_OVERRUN];
                        fe_clr  = reg_wdata[ST_FRAME_ERR];
                    end
                end
                REG_TXDATA: begin
                    if (reg_wstrb[0]) begin
                        if (tx_full) wr_err  = ERR_FIFO;
                        else         tx_push = 1'b1;
                    end
                end
                default: wr_err = ERR_DECODE;
            endcase
        end

        // Read data and error are captured together and held until the next read.
        if (reg_ren) begin
            rdata_d  = '0;
            rd_err_d = ERR_NONE;
            case (addr_ext)
                REG_CTRL:   rdata_d = DATA_WIDTH'(ctrl_q);
                REG_BAUD:   rdata_d = DATA_WIDTH'(baud_q);
                REG_STATUS: rdata_d = status_word;
                REG_RXDATA: begin
                    if (rx_empty) begin
                        rd_err_d = ERR_FIFO;
                    end else begin
                        rdata_d = DATA_WIDTH'(rx_head);
                        rx_pop  = 1'b1;
                    end
                end
                default: rd_err_d = ERR_DECODE;
            endcase
        end
    end

    // Sticky flags: a new event in the same cycle as a W1C wins.
    always_comb begin
        overrun_d   = (rx_push & rx_full & ~rx_pop) | (overrun_q & ~ovr_clr);
        frame_err_d = rx_frame_err | (frame_err_q & ~fe_clr);
        irq_d       = (ctrl_q[CTRL_RX_IE]  & ~rx_empty)
                    | (ctrl_q[CTRL_TX_IE]  &  tx_empty)
                    | (ctrl_q[CTRL_ERR_IE] & (overrun_q | frame_err_q));
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ctrl_q      <= '0;
            baud_q      <= BAUD_RESET;
            overrun_q   <= 1'b0;
            frame_err_q <= 1'b0;
            irq_q       <= 1'b0;
            rdata_q     <= '0;
            rd_err_q    <= ERR_NONE;
        end else begin
            ctrl_q      <= ctrl_d;
            baud_q      <= baud_d;
            overrun_q   <= overrun_d;
            frame_err_q <= frame_err_d;
            irq_q       <= irq_d;
            rdata_q     <= rdata_d;
            rd_err_q    <= rd_err_d;
        end
    end

endmodule

// File: tb/tb_uart_regs.sv
// tb/tb_uart_regs.sv - directed self-checking bench for uart_regs
module tb_uart_regs;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  reg_addr;
    logic [31:0] reg_wdata;
    logic [3:0]  reg_wstrb;
    logic        reg_wen;
    logic        reg_ren;
    logic [31:0] reg_rdata;
    logic        reg_error;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_frame_err;
    logic        tx_en;
    logic        rx_en;
    logic [15:0] baud_div;
    logic        irq;

    always #5 clk = ~clk;

    uart_regs dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .reg_addr     (reg_addr),
        .reg_wdata    (reg_wdata),
        .reg_wstrb    (reg_wstrb),
        .reg_wen      (reg_wen),
        .reg_ren      (reg_ren),
        .reg_rdata    (reg_rdata),
        .reg_error    (reg_error),
        .tx_data      (tx_data),
        .tx_valid     (tx_valid),
        .tx_ready     (tx_ready),
        .rx_data      (rx_data),
        .rx_valid     (rx_valid),
        .rx_frame_err (rx_frame_err),
        .tx_en        (tx_en),
        .rx_en        (rx_en),
        .baud_div     (baud_div),
        .irq          (irq)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic reg_write(input logic [3:0] addr, input logic [31:0] data,
                             input logic [3:0] strb, output logic err);
        @(negedge clk);
        reg_addr  = addr;
        reg_wdata = data;
        reg_wstrb = strb;
        reg_wen   = 1'b1;
        #1 err = reg_error;
        @(posedge clk);
        #1 reg_wen = 1'b0;
    endtask

    task automatic reg_read(input logic [3:0] addr, output logic [31:0] data, output logic err);
        @(negedge clk);
        reg_addr = addr;
        reg_ren  = 1'b1;
        @(posedge clk);
        #1 reg_ren = 1'b0;
        data = reg_rdata;
        err  = reg_error;
    endtask

    logic [31:0] rd;
    logic        er;
    int          n_out;

    initial begin
        rst_n = 1'b0; reg_addr = '0; reg_wdata = '0; reg_wstrb = '0;
        reg_wen = 1'b0; reg_ren = 1'b0; tx_ready = 1'b0;
        rx_data = '0; rx_valid = 1'b0; rx_frame_err = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;

        check_eq("rst_irq", irq, 0);
        check_eq("rst_tx_valid", tx_valid, 0);
        check_eq("rst_reg_error", reg_error, 0);
        check_eq("rst_rdata", reg_rdata, 0);
        check_eq("rst_baud_div", baud_div, 434);
        reg_read(4'd2, rd, er);
        check_eq("rst_status", rd, 32'h0000_000A);
        reg_read(4'd1, rd, er);
        check_eq("rst_baud_read", rd, 434);

        reg_write(4'd1, 32'h1234, 4'b0001, er);
        check_eq("baud_wr_err", er, 0);
        check_eq("baud_div_strb", baud_div, 16'h0134);
        reg_read(4'd1, rd, er);
        check_eq("baud_read_strb", rd, 32'h0000_0134);

        for (int i = 0; i < 17; i++) begin
            reg_write(4'd3, 32'h41, 4'b0001, er);
            check_eq($sformatf("tx_push_err_%0d", i), er, (i == 16) ? 1 : 0);
        end
        reg_read(4'd2, rd, er);
        check_eq("tx_full_status", rd, 32'h0000_1009);
        check_eq("tx_valid_disabled", tx_valid, 0);
        reg_write(4'd3, 32'h99, 4'b0000, er);
        check_eq("tx_nostrb_err", er, 0);

        tx_ready = 1'b1;
        reg_write(4'd0, 32'h01, 4'b0001, er);
        check_eq("tx_en_out", tx_en, 1);
        n_out = 0;
        for (int c = 0; c < 60; c++) begin
            @(negedge clk);
            if (tx_valid) begin
                check_eq("tx_byte", tx_data, 8'h41);
                n_out++;
            end
        end
        tx_ready = 1'b0;
        check_eq("tx_byte_count", n_out, 16);
        reg_read(4'd2, rd, er);
        check_eq("tx_drained_status", rd, 32'h0000_000A);

        reg_write(4'd0, 32'h12, 4'b0001, er);
        check_eq("rx_en_out", rx_en, 1);
        @(negedge clk);
        rx_valid = 1'b1; rx_data = 8'h55;
        repeat (17) @(negedge clk);
        rx_valid = 1'b0;
        @(negedge clk);
        check_eq("overrun_irq", irq, 1);
        reg_read(4'd2, rd, er);
        check_eq("rx_full_status", rd, 32'h0010_0016);
        reg_write(4'd2, 32'h10, 4'b0001, er);
        reg_read(4'd2, rd, er);
        check_eq("overrun_w1c", rd, 32'h0010_0006);
        check_eq("irq_after_w1c", irq, 0);

        @(negedge clk);
        reg_addr = 4'd4; reg_ren = 1'b1; rx_valid = 1'b1; rx_data = 8'h66;
        @(posedge clk);
        #1 reg_ren = 1'b0; rx_valid = 1'b0;
        check_eq("rx_pop_push_data", reg_rdata, 32'h55);
        check_eq("rx_pop_push_err", reg_error, 0);
        reg_read(4'd2, rd, er);
        check_eq("rx_pop_push_status", rd, 32'h0010_0006);
        for (int i = 0; i < 15; i++) begin
            reg_read(4'd4, rd, er);
            check_eq($sformatf("rx_drain_%0d", i), rd, 32'h55);
        end
        reg_read(4'd4, rd, er);
        check_eq("rx_last_byte", rd, 32'h66);
        reg_read(4'd4, rd, er);
        check_eq("rx_empty_rdata", rd, 0);
        check_eq("rx_empty_err", er, 1);
        reg_read(4'd2, rd, er);
        check_eq("rx_empty_status", rd, 32'h0000_000A);

        @(negedge clk) rx_frame_err = 1'b1;
        @(negedge clk) rx_frame_err = 1'b0;
        @(negedge clk);
        check_eq("frame_irq", irq, 1);
        reg_read(4'd2, rd, er);
        check_eq("frame_status", rd, 32'h0000_002A);
        @(negedge clk);
        reg_addr = 4'd2; reg_wdata = 32'h20; reg_wstrb = 4'b0001; reg_wen = 1'b1;
        rx_frame_err = 1'b1;
        @(posedge clk);
        #1 reg_wen = 1'b0; rx_frame_err = 1'b0;
        reg_read(4'd2, rd, er);
        check_eq("frame_set_wins", rd, 32'h0000_002A);
        reg_write(4'd2, 32'h20, 4'b0001, er);
        reg_read(4'd2, rd, er);
        check_eq("frame_w1c", rd, 32'h0000_000A);

        reg_read(4'd3, rd, er);
        check_eq("rd_txdata_data", rd, 0);
        check_eq("rd_txdata_err", er, 1);
        reg_read(4'd7, rd, er);
        check_eq("rd_bad_addr_err", er, 1);
        reg_read(4'd0, rd, er);
        check_eq("rd_ctrl_data", rd, 32'h12);
        check_eq("rd_ctrl_err", er, 0);
        reg_write(4'd4, 32'hAB, 4'b1111, er);
        check_eq("wr_rxdata_err", er, 1);
        reg_write(4'd6, 32'hAB, 4'b1111, er);
        check_eq("wr_bad_addr_err", er, 1);
        reg_read(4'd0, rd, er);
        check_eq("bad_wr_no_effect", rd, 32'h12);

        reg_write(4'd0, 32'h07, 4'b0001, er);
        for (int i = 0; i < 8; i++) reg_write(4'd3, 32'h10 + i, 4'b0001, er);
        @(negedge clk);
        rx_valid = 1'b1; rx_data = 8'h77;
        repeat (8) @(negedge clk);
        rx_valid = 1'b0;
        @(negedge clk);
        check_eq("pre_rst_irq", irq, 1);
        check_eq("pre_rst_tx_valid", tx_valid, 1);
        check_eq("pre_rst_tx_data", tx_data, 8'h10);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check_eq("mid_rst_tx_valid", tx_valid, 0);
        check_eq("mid_rst_irq", irq, 0);
        check_eq("mid_rst_tx_en", tx_en, 0);
        check_eq("mid_rst_rdata", reg_rdata, 0);
        @(negedge clk) rst_n = 1'b1;
        reg_read(4'd2, rd, er);
        check_eq("post_rst_status", rd, 32'h0000_000A);
        reg_read(4'd1, rd, er);
        check_eq("post_rst_baud", rd, 434);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
